// File: rtl/acc_control_fsm.sv
// Free-running load/accumulate/hold sequencer for the neuron MAC accumulator.
// Drives operand select and register enable for N_NEURONS dot products, then parks in DONE.
module acc_control_fsm #(
  parameter int N_TERMS     = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int N_NEURONS   = 3
) (
  input  logic clk,
  input  logic rst,
  output logic sel,
  output logic en
);

  localparam int TERM_W    = (N_TERMS > 1)     ? $clog2(N_TERMS)     : 1;
  localparam int HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int NEUR_W    = (N_NEURONS > 1)   ? $clog2(N_NEURONS)   : 1;
  localparam int TERM_LAST = (N_TERMS > 1)     ? N_TERMS - 2         : 0;
  localparam int HOLD_LAST = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1     : 0;
  localparam int NEUR_LAST = N_NEURONS - 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ACC  = 3'd2,
    HOLD = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  state_t              w_after_neuron;
  state_t              w_after_terms;
  logic [TERM_W-1:0]   r_term_cnt;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [NEUR_W-1:0]   r_neuron;
  logic                r_sel;
  logic                r_en;
  logic                w_last_term;
  logic                w_last_hold;
  logic                w_last_neuron;

  assign w_last_term   = (r_term_cnt == TERM_W'(TERM_LAST));
  assign w_last_hold   = (r_hold_cnt == HOLD_W'(HOLD_LAST));
  assign w_last_neuron = (r_neuron   == NEUR_W'(NEUR_LAST));

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_after_neuron = w_last_neuron ? DONE : LOAD;
    w_after_terms  = (HOLD_CYCLES > 0) ? HOLD : w_after_neuron;
    w_state_nxt    = r_state;
    case (r_state)
      IDLE:    w_state_nxt = LOAD;
      LOAD:    w_state_nxt = (N_TERMS > 1) ? ACC : w_after_terms;
      ACC:     if (w_last_term) w_state_nxt = w_after_terms;
      HOLD:    if (w_last_hold) w_state_nxt = w_after_neuron;
      DONE:    w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counters clear on entry to their state and only advance while in it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_term_cnt <= '0;
      r_hold_cnt <= '0;
      r_neuron   <= '0;
    end else begin
      if (w_state_nxt == ACC && r_state != ACC) begin
        r_term_cnt <= '0;
      end else if (r_state == ACC) begin
        r_term_cnt <= r_term_cnt + TERM_W'(1);
      end

      if (w_state_nxt == HOLD && r_state != HOLD) begin
        r_hold_cnt <= '0;
      end else if (r_state == HOLD) begin
        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
      end

      if (r_state == IDLE) begin
        r_neuron <= '0;
      end else if (w_state_nxt == LOAD) begin
        r_neuron <= r_neuron + NEUR_W'(1);
      end
    end
  end

  // Outputs are decoded from the next state into flops so they change with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel <= 1'b0;
      r_en  <= 1'b0;
    end else begin
      r_sel <= (w_state_nxt == ACC)  || (w_state_nxt == HOLD);
      r_en  <= (w_state_nxt == LOAD) || (w_state_nxt == ACC);
    end
  end

  assign sel = r_sel;
  assign en  = r_en;

endmodule

// File: tb/tb_acc_control_fsm.sv
// Scoreboard bench for acc_control_fsm: three configurations run side by side from one clock and reset.
module tb_acc_control_fsm;

  logic clk;
  logic rst;
  logic sel_a, en_a;
  logic sel_b, en_b;
  logic sel_c, en_c;

  int n_checks;
  int n_fail;

  logic [1:0] q_a[$];
  logic [1:0] q_b[$];
  logic [1:0] q_c[$];

  acc_control_fsm #(.N_TERMS(4), .HOLD_CYCLES(2), .N_NEURONS(3)) u_dut_a (
    .clk(clk), .rst(rst), .sel(sel_a), .en(en_a)
  );
  acc_control_fsm #(.N_TERMS(1), .HOLD_CYCLES(0), .N_NEURONS(2)) u_dut_b (
    .clk(clk), .rst(rst), .sel(sel_b), .en(en_b)
  );
  acc_control_fsm #(.N_TERMS(3), .HOLD_CYCLES(0), .N_NEURONS(3)) u_dut_c (
    .clk(clk), .rst(rst), .sel(sel_c), .en(en_c)
  );

  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Expected {sel,en} per cycle: LOAD, N_TERMS-1 ACC, HOLD_CYCLES HOLD per neuron, then DONE forever.
  task automatic build(output logic [1:0] q[$], input int nt, input int hc, input int nn, input int total);
    q = {};
    for (int n = 0; n < nn; n++) begin
      q.push_back(2'b01);
      for (int t = 1; t < nt; t++) q.push_back(2'b11);
      for (int h = 0; h < hc; h++) q.push_back(2'b10);
    end
    while (q.size() < total) q.push_back(2'b00);
  endtask

  task automatic load_all(input int total);
    build(q_a, 4, 2, 3, total);
    build(q_b, 1, 0, 2, total);
    build(q_c, 3, 0, 3, total);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_a"}, int'({sel_a, en_a}), 0);
    check({tag, "_b"}, int'({sel_b, en_b}), 0);
    check({tag, "_c"}, int'({sel_c, en_c}), 0);
  endtask

  task automatic pop_check(input string tag, inout logic [1:0] q[$], input logic [1:0] got);
    logic [1:0] exp;
    if (q.size() == 0) begin
      check({tag, "_q_empty"}, 1, 0);
    end else begin
      exp = q.pop_front();
      check(tag, int'(got), int'(exp));
    end
  endtask

  // Samples on falling edges, midway between output updates.
  task automatic run_sched(input int n, output int en_cnt_a);
    en_cnt_a = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pop_check("sched_a", q_a, {sel_a, en_a});
      pop_check("sched_b", q_b, {sel_b, en_b});
      pop_check("sched_c", q_c, {sel_c, en_c});
      if (en_a) en_cnt_a++;
    end
  endtask

  initial begin
    int en_cnt;
    n_checks = 0;
    n_fail   = 0;

    rst = 1'b1;
    #1;
    check_zero("rst_t1");
    @(negedge clk);
    check_zero("rst_t40");
    @(negedge clk);
    check_zero("rst_t80");
    #30;
    check_zero("rst_t110");
    #10;
    rst = 1'b0;
    load_all(47);
    run_sched(47, en_cnt);
    check("en_total_a", en_cnt, 12);

    // Full re-run, then a reset pulse during ACC of neuron 1.
    #10;
    rst = 1'b1;
    #1;
    check_zero("rst_async_done");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    q_a = {}; q_b = {}; q_c = {};
    load_all(3);
    run_sched(3, en_cnt);
    #10;
    rst = 1'b1;
    #1;
    check_zero("rst_pulse_acc");
    #19;
    rst = 1'b0;
    @(negedge clk);
    check_zero("idle_after_pulse");
    load_all(30);
    run_sched(30, en_cnt);
    check("en_total_restart_a", en_cnt, 12);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
